// File: rtl/down_counter_if.sv
// Load/control/status bundle of the down counter; the counter sits on the slave side.
interface down_counter_if #(
  parameter int unsigned cnt_WIDTH = 4
);
  logic                 cnt_load_valid;
  logic                 cnt_load_ready;
  logic [cnt_WIDTH-1:0] cnt_load_val;
  logic                 cnt_en;
  logic                 cnt_auto;
  logic                 cnt_abort;
  logic [cnt_WIDTH-1:0] cnt_o;
  logic                 cnt_busy;
  logic                 cnt_done;

  modport master (
    output cnt_load_valid, cnt_load_val, cnt_en, cnt_auto, cnt_abort,
    input  cnt_load_ready, cnt_o, cnt_busy, cnt_done
  );

  modport slave (
    input  cnt_load_valid, cnt_load_val, cnt_en, cnt_auto, cnt_abort,
    output cnt_load_ready, cnt_o, cnt_busy, cnt_done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with optional auto-reload, pause, abort and a
// one-cycle done pulse at terminal count.
module down_counter #(
  parameter int unsigned cnt_WIDTH = 4
) (
  input  logic           cnt_clk,
  input  logic           cnt_rst_n,
  down_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [cnt_WIDTH-1:0] ONE  = cnt_WIDTH'(1);
  localparam logic [cnt_WIDTH-1:0] ZERO = '0;

  state_e               state_q, state_d;
  logic [cnt_WIDTH-1:0] cnt_q, cnt_d;
  logic [cnt_WIDTH-1:0] reload_q, reload_d;
  logic                 done_q, done_d;
  logic                 load_ready;
  logic                 busy;
  logic                 load_accept;

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed by the combinational blocks.
  always_ff @(posedge cnt_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= ZERO;
      reload_q <= ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign load_accept = bus.cnt_load_valid && load_ready;

  // NOTE: every signal gets a default before the if-chain so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (bus.cnt_abort) begin
      // Abort outranks everything and deliberately keeps the reload value.
      state_d = IDLE;
      cnt_d   = ZERO;
    end else if (load_accept) begin
      if (bus.cnt_load_val != ZERO) begin
        state_d  = RUN;
        cnt_d    = bus.cnt_load_val;
        reload_d = bus.cnt_load_val;
      end else begin
        state_d = DONE;
        cnt_d   = ZERO;
        done_d  = 1'b1;
      end
    end else if (state_q == RUN && bus.cnt_en && cnt_q != ZERO) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else if (bus.cnt_auto) begin
        cnt_d  = reload_q;
        done_d = 1'b1;
      end else begin
        state_d = DONE;
        cnt_d   = ZERO;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    load_ready = (state_q == IDLE || state_q == DONE) && !bus.cnt_abort;
    busy       = (state_q == RUN);
  end

  assign bus.cnt_load_ready = load_ready;
  assign bus.cnt_busy       = busy;
  assign bus.cnt_o          = cnt_q;
  assign bus.cnt_done       = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter (width 4): a per-cycle vector table plus
// hand-written asynchronous-reset sequences.
module tb_down_counter;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  down_counter_if #(.cnt_WIDTH(W)) bus ();

  down_counter #(.cnt_WIDTH(W)) dut (
    .cnt_clk   (clk),
    .cnt_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         lv;
    logic [W-1:0] val;
    logic         en;
    logic         au;
    logic         ab;
    logic         rdy;   // ready expected before the edge
    logic [W-1:0] cnt;   // expected after the edge
    logic         done;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lv, input logic [W-1:0] val, input logic en,
                     input logic au, input logic ab, input logic rdy,
                     input logic [W-1:0] cnt, input logic done, input logic busy);
    vec_t v;
    v.lv = lv; v.val = val; v.en = en; v.au = au; v.ab = ab;
    v.rdy = rdy; v.cnt = cnt; v.done = done; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic lv, input logic [W-1:0] val, input logic en,
                       input logic au, input logic ab);
    bus.cnt_load_valid = lv;
    bus.cnt_load_val   = val;
    bus.cnt_en         = en;
    bus.cnt_auto       = au;
    bus.cnt_abort      = ab;
  endtask

  int pulses;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;

    //   lv  val en au ab | rdy cnt done busy
    // load 3, count down to terminal
    add(1, 3, 1, 0, 0,   1, 3, 0, 1);
    add(0, 0, 1, 0, 0,   0, 2, 0, 1);
    add(0, 0, 1, 0, 0,   0, 1, 0, 1);
    add(0, 0, 1, 0, 0,   0, 0, 1, 0);
    add(0, 0, 1, 0, 0,   1, 0, 0, 0);
    // load 0 from DONE
    add(1, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 0, 1, 0, 0,   1, 0, 0, 0);
    // load 2 with auto-reload, 8 enabled cycles
    add(1, 2, 1, 1, 0,   1, 2, 0, 1);
    add(0, 0, 1, 1, 0,   0, 1, 0, 1);
    add(0, 0, 1, 1, 0,   0, 2, 1, 1);
    add(0, 0, 1, 1, 0,   0, 1, 0, 1);
    add(0, 0, 1, 1, 0,   0, 2, 1, 1);
    add(0, 0, 1, 1, 0,   0, 1, 0, 1);
    add(0, 0, 1, 1, 0,   0, 2, 1, 1);
    add(0, 0, 1, 1, 0,   0, 1, 0, 1);
    add(0, 0, 1, 1, 0,   0, 2, 1, 1);
    // abort from RUN
    add(0, 0, 1, 0, 1,   0, 0, 0, 0);
    // load 5, enable pattern 1,0,0,1
    add(1, 5, 0, 0, 0,   1, 5, 0, 1);
    add(0, 0, 1, 0, 0,   0, 4, 0, 1);
    add(0, 0, 0, 0, 0,   0, 4, 0, 1);
    add(0, 0, 0, 0, 0,   0, 4, 0, 1);
    add(0, 0, 1, 0, 0,   0, 3, 0, 1);
    // load request during RUN is ignored
    add(1, 9, 1, 0, 0,   0, 2, 0, 1);
    add(0, 0, 1, 0, 0,   0, 1, 0, 1);
    // abort + load at cnt=1: abort wins, no done
    add(1, 7, 1, 0, 1,   0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   1, 0, 0, 0);
    // abort in IDLE blocks a load
    add(1, 6, 0, 0, 1,   0, 0, 0, 0);
    // reload value 1: done on back-to-back cycles, then stop
    add(1, 1, 1, 1, 0,   1, 1, 0, 1);
    add(0, 0, 1, 1, 0,   0, 1, 1, 1);
    add(0, 0, 1, 1, 0,   0, 1, 1, 1);
    add(0, 0, 1, 0, 0,   0, 0, 1, 0);
    add(0, 0, 1, 0, 0,   1, 0, 0, 0);
    // load max value, pause, abort mid-count
    add(1, 15, 1, 0, 0,  1, 15, 0, 1);
    add(0, 0, 0, 0, 0,   0, 15, 0, 1);
    add(0, 0, 1, 0, 0,   0, 14, 0, 1);
    add(0, 0, 1, 0, 1,   0, 0, 0, 0);

    // Reset state
    #12;
    check("reset_cnt",   bus.cnt_o, 0);
    check("reset_done",  bus.cnt_done, 0);
    check("reset_busy",  bus.cnt_busy, 0);
    check("reset_ready", bus.cnt_load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].lv, vecs[i].val, vecs[i].en, vecs[i].au, vecs[i].ab);
      #1;
      check($sformatf("v%0d_ready", i), bus.cnt_load_ready, vecs[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", i),  bus.cnt_o,    vecs[i].cnt);
      check($sformatf("v%0d_done", i), bus.cnt_done, vecs[i].done);
      check($sformatf("v%0d_busy", i), bus.cnt_busy, vecs[i].busy);
    end

    // Asynchronous reset in the middle of a count of 9
    @(negedge clk);
    drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst9_load_cnt", bus.cnt_o, 9);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst9_cnt8", bus.cnt_o, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst9_async_cnt",  bus.cnt_o, 0);
    check("rst9_async_busy", bus.cnt_busy, 0);
    check("rst9_async_done", bus.cnt_done, 0);
    @(posedge clk); #1;
    check("rst9_held_cnt", bus.cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst9_ready", bus.cnt_load_ready, 1);

    // Full-range count 15..0 after reset release
    @(negedge clk);
    drive(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("full_load_cnt", bus.cnt_o, 15);
    check("full_load_busy", bus.cnt_busy, 1);
    pulses = 0;
    for (int k = 14; k >= 0; k--) begin
      @(negedge clk);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      check($sformatf("full_cnt%0d", k), bus.cnt_o, k);
      if (bus.cnt_done) pulses++;
    end
    check("full_done_at_zero", bus.cnt_done, 1);
    check("full_busy_at_zero", bus.cnt_busy, 0);
    @(posedge clk); #1;
    if (bus.cnt_done) pulses++;
    check("full_done_pulses", pulses, 1);
    check("full_hold_cnt", bus.cnt_o, 0);

    // Reset while a terminal event is pending (cnt=1): no done pulse follows
    @(negedge clk);
    drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pend_cnt1", bus.cnt_o, 1);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("pend_done_suppressed", bus.cnt_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("pend_done_after_release", bus.cnt_done, 0);
    check("pend_cnt_after_release", bus.cnt_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter cnt_WIDTH, default 4: count and load-value width; legal range 2..32.
REQ-002 cnt_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 cnt_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cnt_load_valid  input  1  load request; start value is on cnt_load_val.
REQ-005 cnt_load_ready  output  1  block can accept a load this cycle.
REQ-006 cnt_load_val  input  cnt_WIDTH  start/reload value, unsigned.
REQ-007 cnt_en  input  1  decrement enable; low = pause (hold count).
REQ-008 cnt_auto  input  1  auto-reload mode select, sampled at terminal count.
REQ-009 cnt_abort  input  1  synchronous abort to IDLE.
REQ-010 cnt_o  output  cnt_WIDTH  current count, registered.
REQ-011 cnt_busy  output  1  high while in RUN.
REQ-012 cnt_done  output  1  registered one-cycle pulse at terminal count.

Function
REQ-013 FSM states IDLE, RUN, DONE shall be held in a registered state variable.
REQ-014 cnt_load_ready shall equal (state==IDLE or state==DONE) and not cnt_abort, combinationally.
REQ-015 A load is accepted on an edge where cnt_load_valid and cnt_load_ready are both high; never otherwise.
REQ-016 Accepted load with nonzero value: cnt_o <= cnt_load_val, internal reload register <= cnt_load_val, state <= RUN, cnt_done <= 0.
REQ-017 Accepted load with value 0: cnt_o <= 0, state <= DONE, cnt_done <= 1 (pulse next cycle), regardless of cnt_auto.
REQ-018 In RUN with cnt_en high and cnt_o > 1: cnt_o <= cnt_o - 1, state stays RUN.
REQ-019 In RUN with cnt_en low: cnt_o, state and reload register hold; cnt_done <= 0.
REQ-020 In RUN, cnt_en high, cnt_o == 1, cnt_auto low: cnt_o <= 0, state <= DONE, cnt_done <= 1.
REQ-021 In RUN, cnt_en high, cnt_o == 1, cnt_auto high: cnt_o <= reload register, state stays RUN, cnt_done <= 1; period = reload value enabled cycles.
REQ-022 cnt_done shall be high for exactly one cycle per terminal-count event and low in all other cycles.
REQ-023 DONE holds cnt_o == 0 until a new load or abort; cnt_en has no effect in IDLE or DONE.
REQ-024 cnt_abort high on an edge (any state) shall force state <= IDLE, cnt_o <= 0, cnt_done <= 0, reload register unchanged; abort outranks load and decrement.
REQ-025 Count arithmetic shall never underflow: cnt_o below 1 is never decremented.
REQ-026 cnt_busy shall be derived from the registered state only (state==RUN).

Reset
REQ-027 While cnt_rst_n is low: state = IDLE, cnt_o = 0, reload register = 0, cnt_done = 0, cnt_busy = 0, asynchronously.
REQ-028 On reset deassertion the block is in IDLE with cnt_load_ready = 1 (if cnt_abort low); reset mid-RUN discards count and pending terminal event with no cnt_done pulse.

Verification (cnt_WIDTH = 4)
REQ-029 Load 3, cnt_en=1, cnt_auto=0 -> cnt_o 3,2,1,0 on consecutive cycles; cnt_done one pulse coincident with cnt_o=0; busy drops same cycle; state DONE, ready=1.
REQ-030 Load 2, cnt_auto=1, cnt_en=1 for 8 cycles -> cnt_o 2,1,2,1,...; cnt_done pulses every 2 cycles (4 pulses); busy stays 1; ready=0 throughout.
REQ-031 Load 5, cnt_en toggled 1,0,0,1 -> cnt_o 5,4,4,4,3; no cnt_done.
REQ-032 Load 0 -> next cycle cnt_o=0, cnt_done=1 for one cycle, state DONE, busy never asserted.
REQ-033 In RUN at cnt_o=1 with cnt_en=1, assert cnt_abort and cnt_load_valid (value 7) same edge -> cnt_o=0, IDLE, no cnt_done, load not accepted (ready=0 that cycle).
REQ-034 Load 9, assert cnt_rst_n low mid-count (asynchronous, between edges) -> cnt_o=0, busy=0 immediately; after release, load 15 accepted and counts 15..0 with one cnt_done.
